// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - shared single-port memory request/ready handshake
//
// Signals:
//   mem_req   controller -> memory  access request
//   MemRW     controller -> memory  0 read, 1 write (valid while mem_req=1)
//   AdrSrc    controller -> memory  address select: 0 PC, 1 ALU-out register
//   mem_ready memory -> controller  current request completes this cycle
//
// Modports:
//   master  the multicycle controller (drives the request)
//   slave   the memory port (answers with mem_ready)

interface multicycle_ctrl_if;
    logic mem_req;
    logic MemRW;
    logic AdrSrc;
    logic mem_ready;

    modport master (
        output mem_req,
        output MemRW,
        output AdrSrc,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  MemRW,
        input  AdrSrc,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore FSM sequencing the RV32I multicycle datapath
//
// Build option: MULTICYCLE_TRAP_EN
//   defined   : an illegal opcode parks the FSM in TRAP (illegal=1) until reset
//   undefined : an illegal opcode retires as a NOP (PC+4, no register write)
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst       synchronous active-high reset; forces every output to 0
//   i_Op        opcode IR[6:0], sampled only in DECODE
//   i_br_taken  branch comparator result, used in BRANCH
//   mem         memory handshake (mem_req/MemRW/AdrSrc out, mem_ready in)
//   o_IRWrite   load IR and OldPC
//   o_PCWrite   update PC
//   o_PCSel     00 OldPC+4, 01 ALU result, 10 ALU result & ~1
//   o_RegWEn    register-file write enable
//   o_ImmSel    00 I, 01 S, 10 B, 11 J/U
//   o_ASel      ALU A: 0 rs1, 1 OldPC
//   o_BSel      ALU B: 0 rs2, 1 immediate
//   o_ALUOp     00 ADD, 01 SUB/compare, 10 funct-decoded
//   o_WBSel     00 ALU, 01 memory data, 10 OldPC+4, 11 immediate
//   o_illegal   illegal-opcode flag
//   o_instret   instructions retired since reset (wraps)

module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [6:0]           i_Op,
    input  logic                 i_br_taken,
    multicycle_ctrl_if.master    mem,
    output logic                 o_IRWrite,
    output logic                 o_PCWrite,
    output logic [1:0]           o_PCSel,
    output logic                 o_RegWEn,
    output logic [1:0]           o_ImmSel,
    output logic                 o_ASel,
    output logic                 o_BSel,
    output logic [1:0]           o_ALUOp,
    output logic [1:0]           o_WBSel,
    output logic                 o_illegal,
    output logic [CNT_W-1:0]     o_instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMADR,
        S_MEMRD,
        S_MEMWR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_WB_IMM,
        S_TRAP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    // Op is only valid on the IR in DECODE from the FSM's point of view, so the
    // later states that still need to tell instruction variants apart use this copy.
    logic [6:0]         r_op;
    logic [CNT_W-1:0]   r_instret;

    logic       w_mem_req;
    logic       w_mem_rw;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_pc_write;
    logic [1:0] w_pc_sel;
    logic       w_reg_wen;
    logic [1:0] w_imm_sel;
    logic       w_a_sel;
    logic       w_b_sel;
    logic [1:0] w_alu_op;
    logic [1:0] w_wb_sel;
    logic       w_illegal;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= i_Op;
            end
            if (w_pc_write) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_mem_rw   = 1'b0;
        w_adr_src  = 1'b0;
        w_ir_write = 1'b0;
        w_pc_write = 1'b0;
        w_pc_sel   = 2'b00;
        w_reg_wen  = 1'b0;
        w_imm_sel  = 2'b00;
        w_a_sel    = 1'b0;
        w_b_sel    = 1'b0;
        w_alu_op   = 2'b00;
        w_wb_sel   = 2'b00;
        w_illegal  = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end

            S_DECODE: begin
                case (i_Op)
                    OP_R, OP_I, OP_AUIPC: w_next = S_EXEC;
                    OP_LOAD, OP_STORE:    w_next = S_MEMADR;
                    OP_BRANCH:            w_next = S_BRANCH;
                    OP_JAL, OP_JALR:      w_next = S_JUMP;
                    OP_LUI:               w_next = S_WB_IMM;
                    default:              w_next = S_TRAP;
                endcase
            end

            S_EXEC: begin
                case (r_op)
                    OP_I: begin
                        w_b_sel  = 1'b1;
                        w_alu_op = 2'b10;
                    end
                    OP_AUIPC: begin
                        w_a_sel   = 1'b1;
                        w_b_sel   = 1'b1;
                        w_imm_sel = 2'b11;
                    end
                    default: begin
                        w_alu_op = 2'b10;
                    end
                endcase
                w_next = S_WB_ALU;
            end

            S_MEMADR: begin
                w_b_sel = 1'b1;
                if (r_op == OP_STORE) begin
                    w_imm_sel = 2'b01;
                    w_next    = S_MEMWR;
                end else begin
                    w_next = S_MEMRD;
                end
            end

            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (mem.mem_ready) begin
                    w_next = S_WB_MEM;
                end
            end

            S_MEMWR: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                w_mem_rw  = 1'b1;
                // A store has no write-back, so it retires in its completion cycle.
                if (mem.mem_ready) begin
                    w_pc_write = 1'b1;
                    w_next     = S_FETCH;
                end
            end

            S_WB_ALU: begin
                w_reg_wen  = 1'b1;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end

            S_WB_MEM: begin
                w_reg_wen  = 1'b1;
                w_wb_sel   = 2'b01;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end

            S_WB_IMM: begin
                w_reg_wen  = 1'b1;
                w_wb_sel   = 2'b11;
                w_imm_sel  = 2'b11;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end

            S_BRANCH: begin
                w_a_sel    = 1'b1;
                w_b_sel    = 1'b1;
                w_imm_sel  = 2'b10;
                w_pc_write = 1'b1;
                w_pc_sel   = i_br_taken ? 2'b01 : 2'b00;
                w_next     = S_FETCH;
            end

            S_JUMP: begin
                // The ALU computes the target; the link value OldPC+4 is written back.
                if (r_op == OP_JALR) begin
                    w_pc_sel = 2'b10;
                end else begin
                    w_a_sel   = 1'b1;
                    w_imm_sel = 2'b11;
                    w_pc_sel  = 2'b01;
                end
                w_b_sel    = 1'b1;
                w_reg_wen  = 1'b1;
                w_wb_sel   = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end

            S_TRAP: begin
`ifdef MULTICYCLE_TRAP_EN
                w_illegal = 1'b1;
                w_next    = S_TRAP;
`else
                // Unknown opcode retires as a NOP: advance PC, write nothing.
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
`endif
            end

            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset masks every output combinationally so nothing fires in the reset cycle,
    // even when reset lands in the middle of a memory access.
    assign mem.mem_req = w_mem_req  & ~i_rst;
    assign mem.MemRW   = w_mem_rw   & ~i_rst;
    assign mem.AdrSrc  = w_adr_src  & ~i_rst;
    assign o_IRWrite   = w_ir_write & ~i_rst;
    assign o_PCWrite   = w_pc_write & ~i_rst;
    assign o_PCSel     = i_rst ? 2'b00 : w_pc_sel;
    assign o_RegWEn    = w_reg_wen  & ~i_rst;
    assign o_ImmSel    = i_rst ? 2'b00 : w_imm_sel;
    assign o_ASel      = w_a_sel    & ~i_rst;
    assign o_BSel      = w_b_sel    & ~i_rst;
    assign o_ALUOp     = i_rst ? 2'b00 : w_alu_op;
    assign o_WBSel     = i_rst ? 2'b00 : w_wb_sel;
    assign o_illegal   = w_illegal  & ~i_rst;
    assign o_instret   = i_rst ? '0 : r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl

module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       MemRW;
        logic       AdrSrc;
        logic       IRWrite;
        logic       PCWrite;
        logic [1:0] PCSel;
        logic       RegWEn;
        logic [1:0] ImmSel;
        logic       ASel;
        logic       BSel;
        logic [1:0] ALUOp;
        logic [1:0] WBSel;
        logic       illegal;
    } ctrl_t;

    logic        clk;
    logic        rst;
    logic [6:0]  Op;
    logic        br_taken;
    logic        IRWrite, PCWrite, RegWEn, ASel, BSel, illegal;
    logic [1:0]  PCSel, ImmSel, ALUOp, WBSel;
    logic [31:0] instret;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.CNT_W(32)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_Op       (Op),
        .i_br_taken (br_taken),
        .mem        (bus),
        .o_IRWrite  (IRWrite),
        .o_PCWrite  (PCWrite),
        .o_PCSel    (PCSel),
        .o_RegWEn   (RegWEn),
        .o_ImmSel   (ImmSel),
        .o_ASel     (ASel),
        .o_BSel     (BSel),
        .o_ALUOp    (ALUOp),
        .o_WBSel    (WBSel),
        .o_illegal  (illegal),
        .o_instret  (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ctrl_t       exp_q[$];
    logic [31:0] cnt_q[$];
    string       tag_q[$];
    logic [31:0] n_model = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ctrl_t sample_ctrl();
        ctrl_t c;
        c.mem_req = bus.mem_req;
        c.MemRW   = bus.MemRW;
        c.AdrSrc  = bus.AdrSrc;
        c.IRWrite = IRWrite;
        c.PCWrite = PCWrite;
        c.PCSel   = PCSel;
        c.RegWEn  = RegWEn;
        c.ImmSel  = ImmSel;
        c.ASel    = ASel;
        c.BSel    = BSel;
        c.ALUOp   = ALUOp;
        c.WBSel   = WBSel;
        c.illegal = illegal;
        return c;
    endfunction

    // Scoreboard consumer: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctrl_t       e;
            logic [31:0] n;
            string       t;
            e = exp_q.pop_front();
            n = cnt_q.pop_front();
            t = tag_q.pop_front();
            check_eq({t, "_ctrl"}, 32'(sample_ctrl()), 32'(e));
            check_eq({t, "_instret"}, instret, n);
        end
    end

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    // Drives one cycle of inputs and records what the controller must show in it.
    task automatic step(input logic rdy, input logic [6:0] op, input logic br,
                        input logic rst_v, input ctrl_t e, input string tag);
        @(posedge clk);
        #1;
        rst           = rst_v;
        bus.mem_ready = rdy;
        Op            = op;
        br_taken      = br;
        if (rst_v) n_model = 0;
        exp_q.push_back(e);
        cnt_q.push_back(n_model);
        tag_q.push_back(tag);
        if (!rst_v && e.PCWrite) n_model = n_model + 1;
    endtask

    task automatic do_reset(input int cycles);
        ctrl_t z;
        z = '0;
        for (int i = 0; i < cycles; i++) step(1'b1, rnd_op(), 1'b0, 1'b1, z, "reset");
    endtask

    task automatic do_fetch(input int waits);
        ctrl_t e;
        e = '0;
        e.mem_req = 1'b1;
        for (int i = 0; i < waits; i++) step(1'b0, rnd_op(), 1'b0, 1'b0, e, "fetch_wait");
        e.IRWrite = 1'b1;
        step(1'b1, rnd_op(), 1'b0, 1'b0, e, "fetch");
    endtask

    task automatic exec(input logic [6:0] op, input logic br, input int fw, input int mw);
        ctrl_t e;
        do_fetch(fw);
        e = '0;
        step(1'($urandom), op, 1'b0, 1'b0, e, "decode");
        case (op)
            7'b0110011, 7'b0010011, 7'b0010111: begin
                e = '0;
                if (op == 7'b0010111) begin
                    e.ASel = 1'b1; e.BSel = 1'b1; e.ImmSel = 2'b11;
                end else begin
                    e.ALUOp = 2'b10;
                    e.BSel  = (op == 7'b0010011);
                end
                step(1'($urandom), rnd_op(), 1'b0, 1'b0, e, "exec");
                e = '0; e.RegWEn = 1'b1; e.PCWrite = 1'b1;
                step(1'($urandom), rnd_op(), 1'b0, 1'b0, e, "wb_alu");
            end
            7'b0000011, 7'b0100011: begin
                e = '0; e.BSel = 1'b1;
                e.ImmSel = (op == 7'b0100011) ? 2'b01 : 2'b00;
                step(1'($urandom), rnd_op(), 1'b0, 1'b0, e, "memadr");
                e = '0; e.mem_req = 1'b1; e.AdrSrc = 1'b1;
                e.MemRW = (op == 7'b0100011);
                for (int i = 0; i < mw; i++) step(1'b0, rnd_op(), 1'b0, 1'b0, e, "mem_wait");
                if (op == 7'b0100011) begin
                    e.PCWrite = 1'b1;
                    step(1'b1, rnd_op(), 1'b0, 1'b0, e, "memwr");
                end else begin
                    step(1'b1, rnd_op(), 1'b0, 1'b0, e, "memrd");
                    e = '0; e.RegWEn = 1'b1; e.WBSel = 2'b01; e.PCWrite = 1'b1;
                    step(1'($urandom), rnd_op(), 1'b0, 1'b0, e, "wb_mem");
                end
            end
            7'b1100011: begin
                e = '0; e.ASel = 1'b1; e.BSel = 1'b1; e.ImmSel = 2'b10;
                e.PCWrite = 1'b1; e.PCSel = br ? 2'b01 : 2'b00;
                step(1'($urandom), rnd_op(), br, 1'b0, e, "branch");
            end
            7'b1101111, 7'b1100111: begin
                e = '0; e.BSel = 1'b1; e.RegWEn = 1'b1; e.WBSel = 2'b10; e.PCWrite = 1'b1;
                if (op == 7'b1101111) begin
                    e.ASel = 1'b1; e.ImmSel = 2'b11; e.PCSel = 2'b01;
                end else begin
                    e.PCSel = 2'b10;
                end
                step(1'($urandom), rnd_op(), 1'b0, 1'b0, e, "jump");
            end
            7'b0110111: begin
                e = '0; e.RegWEn = 1'b1; e.WBSel = 2'b11; e.ImmSel = 2'b11; e.PCWrite = 1'b1;
                step(1'($urandom), rnd_op(), 1'b0, 1'b0, e, "wb_imm");
            end
            default: begin
`ifdef MULTICYCLE_TRAP_EN
                e = '0; e.illegal = 1'b1;
                for (int i = 0; i < 20; i++) step(1'($urandom), rnd_op(), 1'b0, 1'b0, e, "trap");
`else
                e = '0; e.PCWrite = 1'b1;
                step(1'($urandom), rnd_op(), 1'b0, 1'b0, e, "nop_retire");
`endif
            end
        endcase
    endtask

    initial begin
        ctrl_t e;
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        Op            = '0;
        br_taken      = 1'b0;

        do_reset(3);
        exec(7'b0110011, 1'b0, 0, 0);   // add
        exec(7'b0000011, 1'b0, 2, 2);   // lw with waits in FETCH and MEMRD
        exec(7'b1100011, 1'b1, 0, 0);   // beq taken
        exec(7'b1100011, 1'b0, 0, 0);   // beq not taken
        exec(7'b1100111, 1'b0, 0, 0);   // jalr
        exec(7'b1101111, 1'b0, 1, 0);   // jal
        exec(7'b0100011, 1'b0, 0, 1);   // sw with one wait
        exec(7'b0010011, 1'b0, 0, 0);   // addi
        exec(7'b0010111, 1'b0, 0, 0);   // auipc
        exec(7'b0110111, 1'b0, 0, 0);   // lui
        exec(7'b0000011, 1'b0, 0, 0);   // lw, no waits

        // Reset lands while a load is waiting on memory.
        do_fetch(0);
        e = '0;
        step(1'b0, 7'b0000011, 1'b0, 1'b0, e, "decode");
        e.BSel = 1'b1;
        step(1'b0, rnd_op(), 1'b0, 1'b0, e, "memadr");
        e = '0; e.mem_req = 1'b1; e.AdrSrc = 1'b1;
        step(1'b0, rnd_op(), 1'b0, 1'b0, e, "mem_wait");
        do_reset(1);
        exec(7'b0110011, 1'b0, 0, 0);

        exec(7'b0000000, 1'b0, 0, 0);   // illegal opcode
`ifdef MULTICYCLE_TRAP_EN
        do_reset(2);
`endif
        exec(7'b0110011, 1'b0, 0, 0);

        @(negedge clk);
        #1;
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore state-machine controller that sequences the RV32I core's datapath over several cycles per instruction. A single-port memory is shared between instruction fetch and load/store. The block sits between the instruction register and the shared datapath (register file, immediate generator, ALU, memory port, PC register). It drives the same control fields as the single-cycle decoder, plus the multicycle strobes, a memory request/ready handshake and a retired-instruction counter.

## Interface
- CNT_W, 32, width of retired-instruction counter `instret`
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- Op  in  7  opcode from instruction register (IR[6:0])
- br_taken  in  1  branch-comparator result for current IR funct3
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory access request
- MemRW  out  1  0 read, 1 write (valid while mem_req=1)
- AdrSrc  out  1  memory address: 0 PC, 1 ALU-out register
- IRWrite  out  1  load IR and OldPC from fetched word / PC
- PCWrite  out  1  update PC this cycle
- PCSel  out  2  00 OldPC+4, 01 ALU result, 10 ALU result & ~1
- RegWEn  out  1  register-file write enable
- ImmSel  out  2  00 I, 01 S, 10 B, 11 J/U (same coding as decoder)
- ASel  out  1  ALU A: 0 rs1, 1 OldPC
- BSel  out  1  ALU B: 0 rs2, 1 immediate
- ALUOp  out  2  00 ADD, 01 SUB/compare, 10 funct-decoded
- WBSel  out  2  00 ALU, 01 memory data, 10 OldPC+4, 11 immediate
- illegal  out  1  illegal-opcode flag
- instret  out  CNT_W  instructions retired since reset

## Operation
- States: FETCH, DECODE, EXEC, MEMADR, MEMRD, MEMWR, WB_ALU, WB_MEM, BRANCH, JUMP, WB_IMM, TRAP.
- FETCH: mem_req=1, AdrSrc=0, MemRW=0. When mem_ready=1: IRWrite=1, go to DECODE. Otherwise hold with identical outputs.
- DECODE: no enables asserted. Dispatch on Op:
  - 0110011 and 0010011 → EXEC (BSel=0 and 1 respectively, ALUOp=10)
  - 0000011 and 0100011 → MEMADR
  - 1100011 → BRANCH
  - 1101111 and 1100111 → JUMP
  - 0110111 → WB_IMM
  - 0010111 → EXEC with ASel=1, BSel=1, ImmSel=11, ALUOp=00
  - any other opcode → TRAP
- EXEC: ALU operates, result is registered → WB_ALU.
- MEMADR: BSel=1, ALUOp=00, ImmSel=00 for load / 01 for store → MEMRD for load, MEMWR for store.
- MEMRD: mem_req=1, AdrSrc=1, MemRW=0; wait on mem_ready → WB_MEM.
- MEMWR: mem_req=1, AdrSrc=1, MemRW=1; wait on mem_ready → FETCH, PCWrite=1, PCSel=00 in the mem_ready cycle.
- WB_ALU / WB_MEM / WB_IMM: RegWEn=1, WBSel=00/01/11 (WB_IMM also drives ImmSel=11), PCWrite=1, PCSel=00 → FETCH.
- BRANCH: ASel=1, BSel=1, ImmSel=10, ALUOp=00, PCWrite=1, PCSel=01 if br_taken else 00 → FETCH.
- JUMP:
  - JAL: ASel=1, ImmSel=11, PCSel=01.
  - JALR: ASel=0, ImmSel=00, PCSel=10.
  - Both: BSel=1, ALUOp=00, RegWEn=1, WBSel=10, PCWrite=1 → FETCH.
- Retire: instret increments by 1 in every cycle with PCWrite=1. It wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0.

## Timing
- Reset: state=FETCH, instret=0, illegal=0.
- While rst=1, all outputs are forced to 0, including mem_req, PCWrite, RegWEn and IRWrite.
- Reset mid-access: the request is dropped and no write enable fires in the reset cycle.
- Handshake rules:
  - mem_req, MemRW and AdrSrc stay stable until the cycle mem_ready=1 is sampled.
  - Completion occurs in that same cycle, and the next state is entered on the following edge.
  - mem_ready while mem_req=0 is ignored.
- Latency with mem_ready tied high:
  - R/I/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch, JAL, JALR, LUI: 3 cycles.
  - Each memory wait cycle adds 1.
- Op is sampled only in DECODE; IR changes only on IRWrite.

## Configuration
- MULTICYCLE_TRAP_EN defined:
  - TRAP is a sink state with all enables 0 and illegal=1.
  - Only rst exits TRAP; instret does not increment.
- MULTICYCLE_TRAP_EN undefined:
  - An illegal opcode executes as a NOP.
  - DECODE → WB_IMM-like retire with RegWEn=0, PCWrite=1, PCSel=00 → FETCH.
  - illegal stays 0 and instret increments.

## Test plan
- Reset held 3 cycles, mem_ready=1, then release → mem_req=0 during reset; mem_req=1, AdrSrc=0 on first cycle after release; instret=0.
- add (0110011) with mem_ready tied 1 → FETCH, DECODE, EXEC, WB_ALU; RegWEn=1, WBSel=00 only in cycle 4; instret=1.
- lw with mem_ready low 2 cycles in both FETCH and MEMRD → 9 cycles total; mem_req and AdrSrc stable while waiting; WBSel=01 with RegWEn=1 in the last cycle.
- beq with br_taken=1, then br_taken=0 → PCSel=01, then 00; PCWrite=1 in cycle 3 each; instret=2.
- jalr → JUMP cycle with RegWEn=1, WBSel=10, PCSel=10, ASel=0.
- Op=0000000 → with MULTICYCLE_TRAP_EN: illegal=1, held for 20 cycles, mem_req=0, instret unchanged. Without it: illegal=0, next FETCH after 3 cycles, instret+1.
